// File: rtl/sp_ctrl_if.sv
// sp_ctrl_if: write-back row stream and read request/response bundle.
// master drives requests and rows, slave (sp_ctrl) answers.
interface sp_ctrl_if #(
  parameter int SP_NTARGETS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 64
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int TW = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;
  localparam int RW = $clog2(MAX_DIM);

  logic                 wb_start_i;
  logic [TW-1:0]        wb_target_i;
  logic                 wb_valid_i;
  logic                 wb_ready_o;
  logic [BUS_WIDTH-1:0] wb_data_i;
  logic                 wb_done_o;

  logic                 rd_req_i;
  logic                 rd_gnt_o;
  logic [TW-1:0]        rd_target_i;
  logic [RW-1:0]        rd_row_i;
  logic                 rd_valid_o;
  logic [BUS_WIDTH-1:0] rd_data_o;

  modport master (
    output wb_start_i, wb_target_i, wb_valid_i, wb_data_i,
    output rd_req_i, rd_target_i, rd_row_i,
    input  wb_ready_o, wb_done_o,
    input  rd_gnt_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  wb_start_i, wb_target_i, wb_valid_i, wb_data_i,
    input  rd_req_i, rd_target_i, rd_row_i,
    output wb_ready_o, wb_done_o,
    output rd_gnt_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/sp_ctrl.sv
// sp_ctrl: scratchpad controller for matrix write-back and row reads.
// Define SP_CTRL_RR_EN for round-robin tie arbitration (default: write wins).
module sp_ctrl #(
  parameter int SP_NTARGETS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 64,
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH,
  localparam int TW = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
  localparam int RW = $clog2(MAX_DIM),
  localparam int AW = $clog2(SP_NTARGETS * MAX_DIM)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  sp_ctrl_if.slave             bus,
  output logic                 sp_we_o,
  output logic [AW-1:0]        sp_addr_o,
  output logic [BUS_WIDTH-1:0] sp_wdata_o,
  input  logic [BUS_WIDTH-1:0] sp_rdata_i,
  output logic                 busy_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_e;

  state_e               state_q;
  logic [TW-1:0]        tgt_q;
  logic [RW-1:0]        row_q;
  logic [BUS_WIDTH-1:0] rd_data_q;
  logic                 err_q;

  logic idle;
  logic beat;
  logic last;
  logic rd_prio;
  logic wr_win;
  logic rd_win;
  logic wr_ok;
  logic rd_ok;
  logic wr_go;
  logic rd_go;
  logic err_set;

  function automatic logic [AW-1:0] row_addr(
    input logic [TW-1:0] t,
    input logic [RW-1:0] r
  );
    return AW'(32'(t) * 32'(MAX_DIM) + 32'(r));
  endfunction

`ifdef SP_CTRL_RR_EN
  // rr_q=1 means the next tie goes to the read side
  logic rr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= 1'b1;
    end else if (idle && bus.wb_start_i && bus.rd_req_i) begin
      rr_q <= ~rr_q;
    end
  end

  assign rd_prio = rr_q;
`else
  assign rd_prio = 1'b0;
`endif

  always_comb begin
    idle   = (state_q == IDLE);
    beat   = (state_q == WRITE) && bus.wb_valid_i;
    last   = (32'(row_q) == 32'(MAX_DIM - 1));
    wr_ok  = (32'(bus.wb_target_i) < 32'(SP_NTARGETS));
    rd_ok  = (32'(bus.rd_target_i) < 32'(SP_NTARGETS));
    wr_win = bus.wb_start_i && !(bus.rd_req_i && rd_prio);
    rd_win = bus.rd_req_i && !(bus.wb_start_i && !rd_prio);
    wr_go  = idle && wr_win && wr_ok;
    rd_go  = idle && rd_win && rd_ok && rst_ni;
    // a start lost in a tie is dropped, not queued
    err_set = (bus.wb_start_i && !idle)
            || (idle && wr_win && !wr_ok)
            || (idle && rd_win && !rd_ok)
            || (idle && bus.wb_start_i && !wr_win);
  end

  always_comb begin
    sp_we_o    = beat;
    sp_addr_o  = '0;
    sp_wdata_o = '0;
    unique case (1'b1)
      beat: begin
        sp_addr_o  = row_addr(tgt_q, row_q);
        sp_wdata_o = bus.wb_data_i;
      end
      rd_go: begin
        sp_addr_o = row_addr(bus.rd_target_i, bus.rd_row_i);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      row_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (err_set) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (wr_go) begin
            tgt_q   <= bus.wb_target_i;
            row_q   <= '0;
            state_q <= WRITE;
          end else if (rd_go) begin
            rd_data_q <= sp_rdata_i;
            state_q   <= READ;
          end
        end
        WRITE: begin
          if (beat) begin
            if (last) begin
              state_q <= DONE;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        READ:    state_q <= IDLE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wb_ready_o = (state_q == WRITE);
  assign bus.wb_done_o  = (state_q == DONE);
  assign bus.rd_gnt_o   = rd_go;
  assign bus.rd_valid_o = (state_q == READ);
  assign bus.rd_data_o  = rd_data_q;
  assign busy_o         = !idle;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sp_ctrl.sv
// tb_sp_ctrl: scoreboard bench for sp_ctrl (MAX_DIM=2, 4 targets),
// plus a 5-target instance for out-of-range target handling.
module tb_sp_ctrl;

`ifdef SP_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [2:0]  a;
    logic [63:0] d;
  } wr_t;

  logic clk;
  logic rst_ni;

  logic        sp_we;
  logic [2:0]  sp_addr;
  logic [63:0] sp_wdata;
  logic [63:0] sp_rdata;
  logic        busy;
  logic        err;

  logic        we5;
  logic [3:0]  addr5;
  logic [63:0] wdata5;
  logic [63:0] rdata5;
  logic        busy5;
  logic        err5;

  logic [63:0] mem  [8];
  logic [63:0] emem [8];
  wr_t         wq[$];
  logic [63:0] rq[$];

  int n_run;
  int n_fail;
  int done_exp;
  int done_seen;

  sp_ctrl_if #(.SP_NTARGETS(4)) b ();
  sp_ctrl_if #(.SP_NTARGETS(5)) b5 ();

  sp_ctrl #(.SP_NTARGETS(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .bus        (b),
    .sp_we_o    (sp_we),
    .sp_addr_o  (sp_addr),
    .sp_wdata_o (sp_wdata),
    .sp_rdata_i (sp_rdata),
    .busy_o     (busy),
    .err_o      (err)
  );

  sp_ctrl #(.SP_NTARGETS(5)) dut5 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .bus        (b5),
    .sp_we_o    (we5),
    .sp_addr_o  (addr5),
    .sp_wdata_o (wdata5),
    .sp_rdata_i (rdata5),
    .busy_o     (busy5),
    .err_o      (err5)
  );

  assign rdata5   = '0;
  assign sp_rdata = mem[sp_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sp_we) mem[sp_addr] <= sp_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sp_we) begin
      if (wq.size() == 0) begin
        chk("wr_unexp", 1, 0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", 64'(sp_addr), 64'(w.a));
        chk("wr_data", sp_wdata, w.d);
      end
    end
    if (b.rd_valid_o) begin
      if (rq.size() == 0) chk("rd_unexp", 1, 0);
      else chk("rd_data", b.rd_data_o, rq.pop_front());
    end
    if (b.wb_done_o) done_seen++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int t, input int r, input logic [63:0] d);
    logic [2:0] a;
    a = 3'(t * 2 + r);
    b.wb_valid_i = 1'b1;
    b.wb_data_i  = d;
    wq.push_back('{a, d});
    emem[a] = d;
  endtask

  task automatic wr_sess(input int t, input logic [63:0] d0,
                         input logic [63:0] d1, input int gap,
                         input bit poke);
    b.wb_start_i  = 1'b1;
    b.wb_target_i = 2'(t);
    cyc();
    b.wb_start_i = 1'b0;
    chk("wr_ready", 64'(b.wb_ready_o), 1);
    beat(t, 0, d0);
    for (int i = 0; i < gap; i++) begin
      cyc();
      b.wb_valid_i  = 1'b0;
      b.wb_start_i  = poke && (i == 0);
      b.wb_target_i = 2'd0;
    end
    cyc();
    b.wb_start_i = 1'b0;
    beat(t, 1, d1);
    cyc();
    b.wb_valid_i = 1'b0;
    chk("wr_done", 64'(b.wb_done_o), 1);
    chk("wr_rdy_off", 64'(b.wb_ready_o), 0);
    done_exp++;
    cyc();
    chk("wr_done_1c", 64'(b.wb_done_o), 0);
    chk("wr_idle", 64'(busy), 0);
  endtask

  task automatic rd(input int t, input int r);
    b.rd_req_i    = 1'b1;
    b.rd_target_i = 2'(t);
    b.rd_row_i    = 1'(r);
    #1;
    chk("rd_gnt", 64'(b.rd_gnt_o), 1);
    chk("rd_addr", 64'(sp_addr), 64'(t * 2 + r));
    chk("rd_we", 64'(sp_we), 0);
    rq.push_back(emem[t * 2 + r]);
    cyc();
    b.rd_req_i = 1'b0;
    chk("rd_valid", 64'(b.rd_valid_o), 1);
    chk("rd_gnt_1c", 64'(b.rd_gnt_o), 0);
    cyc();
    chk("rd_vlow", 64'(b.rd_valid_o), 0);
    chk("rd_hold", b.rd_data_o, emem[t * 2 + r]);
  endtask

  task automatic tie(input bit rdw, input bit exp_err,
                     input logic [63:0] d0, input logic [63:0] d1);
    b.wb_start_i  = 1'b1;
    b.wb_target_i = 2'd2;
    b.rd_req_i    = 1'b1;
    b.rd_target_i = 2'd2;
    b.rd_row_i    = 1'b1;
    #1;
    chk("tie_gnt", 64'(b.rd_gnt_o), 64'(rdw));
    if (rdw) rq.push_back(emem[5]);
    cyc();
    b.wb_start_i = 1'b0;
    b.rd_req_i   = 1'b0;
    chk("tie_wr", 64'(b.wb_ready_o), 64'(!rdw));
    chk("tie_rd", 64'(b.rd_valid_o), 64'(rdw));
    chk("tie_err", 64'(err), 64'(exp_err));
    if (!rdw) begin
      beat(2, 0, d0);
      cyc();
      beat(2, 1, d1);
      cyc();
      b.wb_valid_i = 1'b0;
      chk("tie_done", 64'(b.wb_done_o), 1);
      done_exp++;
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, required $finish");
    $fatal(1);
  end

  initial begin
    n_run = 0; n_fail = 0; done_exp = 0; done_seen = 0;
    rst_ni = 1'b1;
    b.wb_start_i = 1'b0; b.wb_target_i = '0; b.wb_valid_i = 1'b0;
    b.wb_data_i = '0; b.rd_req_i = 1'b1; b.rd_target_i = 2'd2;
    b.rd_row_i = 1'b1;
    b5.wb_start_i = 1'b0; b5.wb_target_i = '0; b5.wb_valid_i = 1'b0;
    b5.wb_data_i = '0; b5.rd_req_i = 1'b0; b5.rd_target_i = '0;
    b5.rd_row_i = 1'b0;
    #2 rst_ni = 1'b0;
    #2;
    chk("rst_gnt", 64'(b.rd_gnt_o), 0);
    chk("rst_addr", 64'(sp_addr), 0);
    chk("rst_we", 64'(sp_we), 0);
    chk("rst_wdata", sp_wdata, 0);
    chk("rst_ready", 64'(b.wb_ready_o), 0);
    chk("rst_done", 64'(b.wb_done_o), 0);
    chk("rst_valid", 64'(b.rd_valid_o), 0);
    chk("rst_rdata", b.rd_data_o, 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err), 0);
    b.rd_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    wr_sess(2, 64'hA, 64'hB, 0, 1'b0);
    cyc(); rd(2, 1);
    cyc(); wr_sess(1, 64'h11, 64'h22, 3, 1'b0);
    chk("gap_err", 64'(err), 0);
    cyc(); rd(1, 0);
    cyc(); rd(2, 0);
    cyc(); wr_sess(3, 64'h33, 64'h44, 2, 1'b1);
    chk("poke_err", 64'(err), 1);
    cyc(); rd(3, 1);

    cyc();
    b.wb_start_i  = 1'b1;
    b.wb_target_i = 2'd0;
    cyc();
    b.wb_start_i = 1'b0;
    beat(0, 0, 64'h55);
    cyc();
    b.wb_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_ready", 64'(b.wb_ready_o), 0);
    chk("arst_err", 64'(err), 0);
    chk("arst_rdata", b.rd_data_o, 0);
    chk("arst_done", 64'(b.wb_done_o), 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    wr_sess(0, 64'h66, 64'h77, 0, 1'b0);
    cyc(); rd(0, 0);
    cyc(); rd(0, 1);

    cyc(); tie(RR, RR, 64'hC1, 64'hD1);
    cyc(); tie(1'b0, RR, 64'hC2, 64'hD2);
    cyc(); rd(2, 1);

    cyc();
    chk("t5_err0", 64'(err5), 0);
    b5.wb_start_i  = 1'b1;
    b5.wb_target_i = 3'd5;
    cyc();
    b5.wb_start_i = 1'b0;
    chk("t5_err", 64'(err5), 1);
    chk("t5_busy", 64'(busy5), 0);
    b5.rd_req_i    = 1'b1;
    b5.rd_target_i = 3'd7;
    #1;
    chk("t5_nognt", 64'(b5.rd_gnt_o), 0);
    cyc();
    b5.rd_req_i = 1'b0;
    chk("t5_rd_busy", 64'(busy5), 0);
    b5.wb_start_i  = 1'b1;
    b5.wb_target_i = 3'd4;
    cyc();
    b5.wb_start_i = 1'b0;
    b5.wb_valid_i = 1'b1;
    b5.wb_data_i  = 64'h99;
    #1;
    chk("t5_we", 64'(we5), 1);
    chk("t5_addr", 64'(addr5), 8);
    chk("t5_wdata", wdata5, 64'h99);
    cyc();
    b5.wb_valid_i = 1'b0;

    cyc(); cyc();
    chk("wq_empty", 64'(wq.size()), 0);
    chk("rq_empty", 64'(rq.size()), 0);
    chk("done_cnt", 64'(done_seen), 64'(done_exp));
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ctrl.md
SP_CTRL -- requirements
Module: sp_ctrl

Interface
REQ-001 SHALL provide parameter SP_NTARGETS, default 4, number of matrix targets held in the scratchpad.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, element width.
REQ-003 SHALL provide parameter BUS_WIDTH, default 64, row width; derived MAX_DIM = BUS_WIDTH/DATA_WIDTH, legal values >= 2.
REQ-004 SHALL provide derived widths TW = $clog2(SP_NTARGETS), RW = $clog2(MAX_DIM) and AW = $clog2(SP_NTARGETS*MAX_DIM).
REQ-005 SHALL use one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-006 clk_i  in  1  clock, all state updates on the rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 wb_start_i  in  1  single-cycle request to begin a matrix write-back.
REQ-009 wb_target_i  in  TW  destination target, sampled with wb_start_i.
REQ-010 wb_valid_i / wb_ready_o  in / out  1 / 1  row handshake; a beat transfers when both are high.
REQ-011 wb_data_i  in  BUS_WIDTH  row data.
REQ-012 wb_done_o  out  1  one-cycle pulse on write-back completion.
REQ-013 rd_req_i / rd_gnt_o  in / out  1 / 1  read request and one-cycle grant.
REQ-014 rd_target_i, rd_row_i  in  TW, RW  read location.
REQ-015 rd_valid_o, rd_data_o  out  1, BUS_WIDTH  registered read response.
REQ-016 sp_we_o, sp_addr_o, sp_wdata_o  out  1, AW, BUS_WIDTH  scratchpad port.
REQ-017 sp_rdata_i  in  BUS_WIDTH  scratchpad combinational read data.
REQ-018 busy_o, err_o  out  1, 1  FSM not in IDLE; sticky error flag.

Function
REQ-019 SHALL implement an FSM with states IDLE, WRITE, READ and DONE.
REQ-020 IDLE: when wb_start_i is granted (REQ-030), SHALL latch wb_target_i, clear row_cnt and go to WRITE.
REQ-021 IDLE: when rd_req_i is granted, SHALL assert rd_gnt_o and set sp_we_o=0 and sp_addr_o={rd_target_i,rd_row_i}, i.e. rd_target_i*MAX_DIM+rd_row_i, combinationally; SHALL register sp_rdata_i into rd_data_o and go to READ.
REQ-022 READ: SHALL assert rd_valid_o for exactly one cycle, hold rd_data_o until the next granted read, and return to IDLE; throughput is one read per 2 cycles.
REQ-023 WRITE: SHALL hold wb_ready_o=1; on each beat SHALL set sp_we_o=1, sp_addr_o=target*MAX_DIM+row_cnt and sp_wdata_o=wb_data_i combinationally in the same cycle, then increment row_cnt.
REQ-024 WRITE: cycles with wb_valid_i=0 SHALL leave row_cnt unchanged and keep sp_we_o=0; gaps are unlimited.
REQ-025 WRITE: the beat with row_cnt=MAX_DIM-1 SHALL go to DONE; row_cnt SHALL never wrap within a session.
REQ-026 DONE: SHALL assert wb_done_o for one cycle, deassert wb_ready_o and return to IDLE.
REQ-027 Outside WRITE, wb_ready_o and sp_we_o SHALL be 0; outside WRITE and READ-grant cycles, sp_addr_o and sp_wdata_o SHALL be 0.
REQ-028 wb_start_i asserted outside IDLE SHALL be ignored and SHALL set err_o.
REQ-029 wb_target_i or rd_target_i >= SP_NTARGETS on a granted request SHALL set err_o and drop the request; the FSM SHALL stay in IDLE.
REQ-030 When wb_start_i and rd_req_i are both asserted in IDLE, the arbitration rule is set by REQ-035/036; the losing rd_req_i SHALL stay pending (no grant) and the losing wb_start_i SHALL be dropped and SHALL set err_o.
REQ-031 rd_req_i asserted outside IDLE SHALL receive no grant until IDLE.

Reset
REQ-032 When rst_ni=0, SHALL asynchronously force the FSM to IDLE, row_cnt and the latched target to 0, and every output to 0, including err_o and rd_data_o.
REQ-033 Reset during WRITE SHALL abandon the session with no wb_done_o; rows already written remain in the scratchpad.
REQ-034 The first request SHALL be accepted on the first rising edge after rst_ni deasserts.

Configuration
REQ-035 With macro SP_CTRL_RR_EN defined, a simultaneous-request tie SHALL alternate round-robin, with read winning the first tie after reset.
REQ-036 Without SP_CTRL_RR_EN, write SHALL always win a simultaneous-request tie.

Verification (MAX_DIM=2, SP_NTARGETS=4)
REQ-037 wb_start_i, target 2; rows 0xA then 0xB on consecutive cycles -> sp_we_o with sp_addr_o 4 then 5; wb_done_o on the next cycle.
REQ-038 Same write with a 3-cycle wb_valid_i gap between rows -> row_cnt holds; still exactly 2 writes and 1 done pulse.
REQ-039 Read target 2, row 1 after REQ-037 -> rd_gnt_o, sp_addr_o=5; rd_valid_o next cycle with rd_data_o=0xB.
REQ-040 wb_start_i during WRITE, and wb_target_i=5 with SP_NTARGETS=5 -> err_o=1 and the session is unaffected.
REQ-041 Tie wb_start_i+rd_req_i twice, with and without SP_CTRL_RR_EN -> read,write versus write,write winners.
REQ-042 rst_ni pulsed low after one written row -> all outputs 0 immediately; no wb_done_o; next wb_start_i accepted.
